coherence_bus_controller: RTL and testbench

- Shared-bus end of the snooping MSI protocol.
- Captures miss/invalidate requests driven by the cpu nodes, arbitrates round-robin, and broadcasts the winning request to every node's bus_in.
- Collects one cycle of snoop responses, absorbs write-backs into the 8x4 main memory, and returns the reply word that completes the requester's miss.

---
 rtl/bus_msg_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/coherence_bus_controller.sv | 190 +++++++++++++++++++
 tb/tb_coherence_bus_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_msg_pkg.sv
// ---------------------------------------------------------------------------
// bus_msg_pkg
// Shared definitions for the snooping-MSI bus controller.
//   - Bit positions of the flag, address and data fields of a bus message
//     (default layout: ADDR_W=3, DATA_W=4, BUS_W=13).
//   - FSM state encoding of the controller.
// ---------------------------------------------------------------------------
package bus_msg_pkg;

    // Flag bits of a bus message
    localparam int BIT_WB    = 12;
    localparam int BIT_ABORT = 11;
    localparam int BIT_VALID = 10;
    localparam int BIT_RM    = 9;
    localparam int BIT_WM    = 8;
    localparam int BIT_INV   = 7;

    // Field base positions
    localparam int ADDR_LSB  = 4;
    localparam int DATA_LSB  = 0;

    // Width of the {read_miss, write_miss, invalidate} op field
    localparam int OP_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        REPLY = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: returns the first set bit of pending_i at
// or after ptr_i, wrapping modulo NUM_CPUS. The pointer register lives in the
// caller.
//   pending_i  in   NUM_CPUS          one bit per node with a request waiting
//   ptr_i      in   $clog2(NUM_CPUS)  highest-priority index this round
//   grant_o    out  $clog2(NUM_CPUS)  selected node index (0 when none)
//   valid_o    out  1                 a node was selected
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_CPUS = 2
) (
    input  logic [NUM_CPUS-1:0]         pending_i,
    input  logic [$clog2(NUM_CPUS)-1:0] ptr_i,
    output logic [$clog2(NUM_CPUS)-1:0] grant_o,
    output logic                        valid_o
);

    localparam int ID_W = $clog2(NUM_CPUS);

    function automatic int wrap_idx(input int base, input int off);
        int sum;
        sum = base + off;
        return (sum >= NUM_CPUS) ? sum - NUM_CPUS : sum;
    endfunction

    // Scan from the farthest offset down so the closest candidate to the
    // pointer is the last one assigned and therefore wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        grant_o = '0;
        valid_o = 1'b0;
        for (int off = NUM_CPUS - 1; off >= 0; off--) begin
            if (pending_i[wrap_idx(int'(ptr_i), off)]) begin
                grant_o = ID_W'(wrap_idx(int'(ptr_i), off));
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coherence_bus_controller.sv
// ---------------------------------------------------------------------------
// coherence_bus_controller
// Shared-bus end of a snooping MSI protocol. Captures miss/invalidate
// requests from the cpu nodes, serves them round-robin, broadcasts the winner,
// samples one cycle of snoop responses, absorbs write-backs into main memory
// and returns the reply word that completes the requester's miss.
//   clock        in   1                 rising-edge clock
//   reset        in   1                 synchronous, active-high
//   cpu_bus_out  in   NUM_CPUS*BUS_W    bus_out of node i at [i*BUS_W +: BUS_W]
//   bus_in       out  BUS_W             registered broadcast to every node
//   grant_id     out  $clog2(NUM_CPUS)  node currently being served
//   busy         out  1                 high from grant until the reply edge
//   dbg_addr     in   ADDR_W            debug memory read address
//   dbg_data     out  DATA_W            combinational mem[dbg_addr]
// ---------------------------------------------------------------------------
module coherence_bus_controller
    import bus_msg_pkg::*;
#(
    parameter int NUM_CPUS = 2,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 4,
    parameter int BUS_W    = 6 + ADDR_W + DATA_W
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_CPUS*BUS_W-1:0]   cpu_bus_out,
    output logic [BUS_W-1:0]            bus_in,
    output logic [$clog2(NUM_CPUS)-1:0] grant_id,
    output logic                        busy,
    input  logic [ADDR_W-1:0]           dbg_addr,
    output logic [DATA_W-1:0]           dbg_data
);

    localparam int ID_W  = $clog2(NUM_CPUS);
    localparam int DEPTH = 2 ** ADDR_W;

    // ---------------- registers ----------------
    state_e              state_q;
    logic [BUS_W-1:0]    bus_in_q;
    logic [ID_W-1:0]     grant_q;
    logic                busy_q;
    logic [ID_W-1:0]     ptr_q;
    logic [NUM_CPUS-1:0] pending_q;
    logic [OP_W-1:0]     req_op_q   [NUM_CPUS];
    logic [ADDR_W-1:0]   req_addr_q [NUM_CPUS];
    logic [ADDR_W-1:0]   cur_addr_q;
    logic [DATA_W-1:0]   reply_data_q;
    logic [DATA_W-1:0]   mem_q      [DEPTH];

    // ---------------- next-state / combinational ----------------
    logic [NUM_CPUS-1:0] pending_d;
    logic [ID_W-1:0]     ptr_d;
    logic [BUS_W-1:0]    node_msg [NUM_CPUS];
    logic [NUM_CPUS-1:0] req_vec;
    logic [ID_W-1:0]     arb_grant;
    logic                arb_valid;
    logic [BUS_W-1:0]    bcast_msg;
    logic [BUS_W-1:0]    reply_msg;
    logic                sup_found;
    logic [DATA_W-1:0]   sup_data;

    // Split the flat input into per-node messages and flag fresh requests.
    for (genvar g = 0; g < NUM_CPUS; g++) begin : g_node
        assign node_msg[g] = cpu_bus_out[g*BUS_W +: BUS_W];
        assign req_vec[g]  = node_msg[g][BIT_VALID] & (|node_msg[g][BIT_RM:BIT_INV]);
    end

    rr_arbiter #(
        .NUM_CPUS (NUM_CPUS)
    ) u_arb (
        .pending_i (pending_q),
        .ptr_i     (ptr_q),
        .grant_o   (arb_grant),
        .valid_o   (arb_valid)
    );

    // Clear the granted node's pending bit, then merge this cycle's requests.
    // The granted node is blocked awaiting its reply, so a fresh request can
    // never collide with the clear.
    always_comb begin
        // NOTE: blocking assignments here build combinational next-state values
        // in order; registered state below is only ever updated with <=.
        pending_d = pending_q;
        if (state_q == IDLE && arb_valid) begin
            pending_d[arb_grant] = 1'b0;
        end
        pending_d = pending_d | req_vec;
    end

    assign ptr_d = (arb_grant == ID_W'(NUM_CPUS - 1)) ? '0 : ID_W'(arb_grant + 1'b1);

    // Broadcast carries op and address with valid clear, so the requester
    // does not mistake it for its reply.
    always_comb begin
        bcast_msg                         = '0;
        bcast_msg[BIT_RM:BIT_INV]         = req_op_q[arb_grant];
        bcast_msg[ADDR_LSB +: ADDR_W]     = req_addr_q[arb_grant];
        reply_msg                         = '0;
        reply_msg[BIT_VALID]              = 1'b1;
        reply_msg[ADDR_LSB +: ADDR_W]     = cur_addr_q;
        reply_msg[DATA_LSB +: DATA_W]     = reply_data_q;
    end

    // Supplier: lowest-index non-requester flushing the granted block.
    // Iterating downward lets the lowest index overwrite higher ones.
    always_comb begin
        sup_found = 1'b0;
        sup_data  = '0;
        for (int i = NUM_CPUS - 1; i >= 0; i--) begin
            if (ID_W'(i) != grant_q
                && node_msg[i][BIT_VALID]
                && (node_msg[i][BIT_WB] || node_msg[i][BIT_ABORT])
                && node_msg[i][ADDR_LSB +: ADDR_W] == cur_addr_q) begin
                sup_found = 1'b1;
                sup_data  = node_msg[i][DATA_LSB +: DATA_W];
            end
        end
    end

    // NOTE: request payload registers carry no reset; pending_q qualifies
    // them, and a stale payload is never read while its pending bit is clear.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CPUS; i++) begin
            if (req_vec[i]) begin
                req_op_q[i]   <= node_msg[i][BIT_RM:BIT_INV];
                req_addr_q[i] <= node_msg[i][ADDR_LSB +: ADDR_W];
            end
        end
    end

    // Transaction FSM, bus output register and main memory.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            bus_in_q     <= '0;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            ptr_q        <= '0;
            pending_q    <= '0;
            cur_addr_q   <= '0;
            reply_data_q <= '0;
            // NOTE: main memory is deliberately reset to mem[k] = k so the
            // system starts from a known image; this rules out RAM macros.
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= DATA_W'(k);
            end
        end else begin
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    bus_in_q <= '0;
                    if (arb_valid) begin
                        grant_q    <= arb_grant;
                        busy_q     <= 1'b1;
                        cur_addr_q <= req_addr_q[arb_grant];
                        bus_in_q   <= bcast_msg;
                        ptr_q      <= ptr_d;
                        state_q    <= SNOOP;
                    end
                end
                SNOOP: begin
                    bus_in_q <= '0;
                    if (sup_found) begin
                        mem_q[cur_addr_q] <= sup_data;
                        reply_data_q      <= sup_data;
                    end else begin
                        reply_data_q      <= mem_q[cur_addr_q];
                    end
                    state_q <= REPLY;
                end
                REPLY: begin
                    bus_in_q <= reply_msg;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    bus_in_q <= '0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus_in   = bus_in_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: tb/tb_coherence_bus_controller.sv
// ---------------------------------------------------------------------------
// tb_coherence_bus_controller
// Directed bench for coherence_bus_controller with two cpu nodes. Inputs are
// driven and outputs sampled on the falling clock edge; all expected words
// are hand-computed from the bus message layout.
// ---------------------------------------------------------------------------
module tb_coherence_bus_controller;

    localparam logic [12:0] M_WB    = 13'h1000;
    localparam logic [12:0] M_VALID = 13'h0400;
    localparam logic [12:0] M_RM    = 13'h0200;
    localparam logic [12:0] M_WM    = 13'h0100;

    logic        clock;
    logic        reset;
    logic [12:0] node0_msg;
    logic [12:0] node1_msg;
    logic [25:0] cpu_bus_out;
    logic [12:0] bus_in;
    logic [0:0]  grant_id;
    logic        busy;
    logic [2:0]  dbg_addr;
    logic [3:0]  dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    assign cpu_bus_out = {node1_msg, node0_msg};

    coherence_bus_controller #(
        .NUM_CPUS (2),
        .ADDR_W   (3),
        .DATA_W   (4),
        .BUS_W    (13)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_bus_out (cpu_bus_out),
        .bus_in      (bus_in),
        .grant_id    (grant_id),
        .busy        (busy),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic logic [12:0] msg(input logic [12:0] flags, input int addr, input int data);
        return flags | 13'((addr & 7) << 4) | 13'(data & 15);
    endfunction

    task automatic peek_mem(input string tag, input int addr, input int exp);
        dbg_addr = 3'(addr);
        #1;
        check(tag, 32'(dbg_data), 32'(exp));
    endtask

    initial begin
        reset     = 1'b1;
        node0_msg = '0;
        node1_msg = '0;
        dbg_addr  = '0;
        repeat (2) tick();

        // Reset state
        check("rst_bus",   32'(bus_in),   32'h0);
        check("rst_busy",  32'(busy),     32'h0);
        check("rst_grant", 32'(grant_id), 32'h0);
        peek_mem("rst_mem3", 3, 3);
        peek_mem("rst_mem7", 7, 7);
        reset = 1'b0;
        tick();

        // 1: node0 read_miss addr 3, no snoop data
        node0_msg = msg(M_VALID | M_RM, 3, 0);
        tick();
        node0_msg = '0;
        check("t1_idle_bus", 32'(bus_in), 32'h0);
        tick();
        check("t1_bcast",     32'(bus_in),   32'h230);
        check("t1_busy",      32'(busy),     32'h1);
        check("t1_grant",     32'(grant_id), 32'h0);
        tick();
        check("t1_snoop_bus", 32'(bus_in),   32'h0);
        check("t1_snoop_bsy", 32'(busy),     32'h1);
        tick();
        check("t1_reply",     32'(bus_in),   32'h433);
        tick();
        check("t1_after_bus", 32'(bus_in),   32'h0);
        check("t1_after_bsy", 32'(busy),     32'h0);

        // 2: node1 read_miss addr 5, node0 supplies 0xA by write-back
        node1_msg = msg(M_VALID | M_RM, 5, 0);
        tick();
        node1_msg = '0;
        tick();
        check("t2_bcast", 32'(bus_in),   32'h250);
        check("t2_grant", 32'(grant_id), 32'h1);
        node0_msg = msg(M_WB | M_VALID, 5, 4'hA);
        tick();
        node0_msg = '0;
        check("t2_snoop_bus", 32'(bus_in), 32'h0);
        tick();
        check("t2_reply", 32'(bus_in), 32'h45A);
        peek_mem("t2_mem5", 5, 4'hA);
        tick();
        check("t2_after_bsy", 32'(busy), 32'h0);

        // 3: simultaneous read misses; pointer is back at node0
        node0_msg = msg(M_VALID | M_RM, 2, 0);
        node1_msg = msg(M_VALID | M_RM, 6, 0);
        tick();
        node0_msg = '0;
        node1_msg = '0;
        tick();
        check("t3_bcast0", 32'(bus_in),   32'h220);
        check("t3_grant0", 32'(grant_id), 32'h0);
        tick();
        tick();
        check("t3_reply0", 32'(bus_in),   32'h422);
        tick();
        check("t3_bcast1", 32'(bus_in),   32'h260);
        check("t3_grant1", 32'(grant_id), 32'h1);
        check("t3_busy1",  32'(busy),     32'h1);
        tick();
        tick();
        check("t3_reply1", 32'(bus_in),   32'h466);
        tick();
        check("t3_after_bus", 32'(bus_in), 32'h0);
        check("t3_after_bsy", 32'(busy),   32'h0);

        // 4: node1 write_miss addr 4; memory untouched
        node1_msg = msg(M_VALID | M_WM, 4, 4'hC);
        tick();
        node1_msg = '0;
        tick();
        check("t4_bcast", 32'(bus_in),   32'h140);
        check("t4_grant", 32'(grant_id), 32'h1);
        tick();
        tick();
        check("t4_reply", 32'(bus_in), 32'h444);
        peek_mem("t4_mem4", 4, 4);
        tick();

        // 5: node0 requests while node1 is in SNOOP
        node1_msg = msg(M_VALID | M_RM, 1, 0);
        tick();
        node1_msg = '0;
        tick();
        check("t5_bcast1", 32'(bus_in),   32'h210);
        check("t5_grant1", 32'(grant_id), 32'h1);
        node0_msg = msg(M_VALID | M_RM, 7, 0);
        tick();
        node0_msg = '0;
        check("t5_snoop_bus", 32'(bus_in), 32'h0);
        tick();
        check("t5_reply1", 32'(bus_in),   32'h411);
        tick();
        check("t5_bcast0", 32'(bus_in),   32'h270);
        check("t5_grant0", 32'(grant_id), 32'h0);
        tick();
        tick();
        check("t5_reply0", 32'(bus_in),   32'h477);
        tick();
        check("t5_after_bsy", 32'(busy), 32'h0);

        // Snoop write-back to a different address is ignored
        node0_msg = msg(M_VALID | M_RM, 0, 0);
        tick();
        node0_msg = '0;
        tick();
        check("mis_bcast", 32'(bus_in), 32'h200);
        node1_msg = msg(M_WB | M_VALID, 1, 4'hF);
        tick();
        node1_msg = '0;
        tick();
        check("mis_reply", 32'(bus_in), 32'h400);
        peek_mem("mis_mem1", 1, 1);
        tick();

        // 6: reset lands on the SNOOP edge with a write-back on the bus
        node0_msg = msg(M_VALID | M_RM, 6, 0);
        tick();
        node0_msg = '0;
        tick();
        check("t6_bcast", 32'(bus_in), 32'h260);
        node1_msg = msg(M_WB | M_VALID, 6, 9);
        reset     = 1'b1;
        tick();
        node1_msg = '0;
        check("t6_rst_bus",   32'(bus_in),   32'h0);
        check("t6_rst_busy",  32'(busy),     32'h0);
        check("t6_rst_grant", 32'(grant_id), 32'h0);
        peek_mem("t6_mem6", 6, 6);
        peek_mem("t6_mem5", 5, 5);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("t6_quiet_bus%0d", c),  32'(bus_in), 32'h0);
            check($sformatf("t6_quiet_busy%0d", c), 32'(busy),   32'h0);
        end

        // Service resumes after reset with the reset memory image
        node1_msg = msg(M_VALID | M_RM, 5, 0);
        tick();
        node1_msg = '0;
        tick();
        check("t7_bcast", 32'(bus_in),   32'h250);
        check("t7_grant", 32'(grant_id), 32'h1);
        tick();
        tick();
        check("t7_reply", 32'(bus_in), 32'h455);
        tick();
        check("t7_after_bsy", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
